// File: rtl/rf_write_arbiter_if.sv
// Register-file write-port bundle: core and debug request channels,
// freeze control, and the registered write port toward the register file.
interface rf_write_arbiter_if;
  logic        freeze;
  logic        c_valid;
  logic [4:0]  c_addr;
  logic [31:0] c_data;
  logic        c_ready;
  logic        d_valid;
  logic [4:0]  d_addr;
  logic [31:0] d_data;
  logic        d_ready;
  logic        rf_wrt_en;
  logic [4:0]  rf_wrt_addr;
  logic [31:0] rf_wrt_data;
  logic [3:0]  starve_cnt;

  // Requester / observer side.
  modport master (
    output freeze,
    output c_valid, c_addr, c_data,
    input  c_ready,
    output d_valid, d_addr, d_data,
    input  d_ready,
    input  rf_wrt_en, rf_wrt_addr, rf_wrt_data,
    input  starve_cnt
  );

  // Arbiter side.
  modport slave (
    input  freeze,
    input  c_valid, c_addr, c_data,
    output c_ready,
    input  d_valid, d_addr, d_data,
    output d_ready,
    output rf_wrt_en, rf_wrt_addr, rf_wrt_data,
    output starve_cnt
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between core writeback and
// debug. Core has fixed priority; a starvation counter forces a debug grant
// after STARVE_MAX consecutive denied cycles. The winning write is registered
// once before driving the register file; x0 writes never assert the enable.
module rf_write_arbiter #(
  parameter int unsigned STARVE_MAX = 4  // legal range 1..15
) (
  input logic               clk,
  input logic               reset,
  rf_write_arbiter_if.slave bus
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic        c_grant;
  logic        d_grant;
  logic [3:0]  starve_cnt_d,  starve_cnt_q;
  logic        rf_wrt_en_d,   rf_wrt_en_q;
  logic [4:0]  rf_wrt_addr_d, rf_wrt_addr_q;
  logic [31:0] rf_wrt_data_d, rf_wrt_data_q;

  // Grant decode: freeze, then forced debug, then core, then debug.
  always_comb begin
    c_grant = 1'b0;
    d_grant = 1'b0;
    if (bus.freeze) begin
      c_grant = 1'b0;
      d_grant = 1'b0;
    end else if (bus.d_valid && (starve_cnt_q == StarveMax)) begin
      d_grant = 1'b1;
    end else if (bus.c_valid) begin
      c_grant = 1'b1;
    end else if (bus.d_valid) begin
      d_grant = 1'b1;
    end
  end

  // Starvation counter next state; holds only while debug waits under freeze.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (bus.d_valid && c_grant) begin
      if (starve_cnt_q < StarveMax) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end else if (d_grant || !bus.d_valid) begin
      starve_cnt_d = 4'd0;
    end
  end

  // Output stage next state: load the winner, enable only for non-x0 targets.
  always_comb begin
    rf_wrt_en_d   = 1'b0;
    rf_wrt_addr_d = rf_wrt_addr_q;
    rf_wrt_data_d = rf_wrt_data_q;
    if (c_grant) begin
      rf_wrt_en_d   = (bus.c_addr != 5'd0);
      rf_wrt_addr_d = bus.c_addr;
      rf_wrt_data_d = bus.c_data;
    end else if (d_grant) begin
      rf_wrt_en_d   = (bus.d_addr != 5'd0);
      rf_wrt_addr_d = bus.d_addr;
      rf_wrt_data_d = bus.d_data;
    end
  end

  // State registers; asynchronous reset drops any in-flight write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q  <= 4'd0;
      rf_wrt_en_q   <= 1'b0;
      rf_wrt_addr_q <= 5'd0;
      rf_wrt_data_q <= 32'd0;
    end else begin
      starve_cnt_q  <= starve_cnt_d;
      rf_wrt_en_q   <= rf_wrt_en_d;
      rf_wrt_addr_q <= rf_wrt_addr_d;
      rf_wrt_data_q <= rf_wrt_data_d;
    end
  end

  // Drive the bundle outputs.
  always_comb begin
    bus.c_ready     = c_grant;
    bus.d_ready     = d_grant;
    bus.starve_cnt  = starve_cnt_q;
    bus.rf_wrt_en   = rf_wrt_en_q;
    bus.rf_wrt_addr = rf_wrt_addr_q;
    bus.rf_wrt_data = rf_wrt_data_q;
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with STARVE_MAX=4.
module tb_rf_write_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  rf_write_arbiter_if bus ();

  rf_write_arbiter #(
    .STARVE_MAX(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.freeze  = 1'b0;
    bus.c_valid = 1'b0;
    bus.c_addr  = 5'd0;
    bus.c_data  = 32'd0;
    bus.d_valid = 1'b0;
    bus.d_addr  = 5'd0;
    bus.d_data  = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    #2 reset = 1'b0;
    tick();
    n_checks++;
    if (bus.rf_wrt_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_en got %0h exp 0", bus.rf_wrt_en);
    end
    n_checks++;
    if (bus.rf_wrt_addr !== 5'd0) begin
      n_fail++; $display("FAIL reset_addr got %0h exp 0", bus.rf_wrt_addr);
    end
    n_checks++;
    if (bus.rf_wrt_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_data got %0h exp 0", bus.rf_wrt_data);
    end
    n_checks++;
    if (bus.starve_cnt !== 4'd0) begin
      n_fail++; $display("FAIL reset_cnt got %0h exp 0", bus.starve_cnt);
    end
    n_checks++;
    if ({bus.c_ready, bus.d_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready got %b exp 00", {bus.c_ready, bus.d_ready});
    end
  endtask

  task automatic test_core_only();
    bus.c_valid = 1'b1;
    bus.c_addr  = 5'd5;
    bus.c_data  = 32'hDEADBEEF;
    #1;
    n_checks++;
    if ({bus.c_ready, bus.d_ready} !== 2'b10) begin
      n_fail++; $display("FAIL core_ready got %b exp 10", {bus.c_ready, bus.d_ready});
    end
    tick();
    bus.c_valid = 1'b0;
    n_checks++;
    if ({bus.rf_wrt_en, bus.rf_wrt_addr, bus.rf_wrt_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL core_write got en=%0h addr=%0d data=%h exp en=1 addr=5 data=deadbeef",
               bus.rf_wrt_en, bus.rf_wrt_addr, bus.rf_wrt_data);
    end
    tick();
    n_checks++;
    if ({bus.rf_wrt_en, bus.rf_wrt_addr} !== {1'b0, 5'd5}) begin
      n_fail++;
      $display("FAIL core_idle got en=%0h addr=%0d exp en=0 addr=5",
               bus.rf_wrt_en, bus.rf_wrt_addr);
    end
  endtask

  task automatic test_contention();
    bus.c_valid = 1'b1;
    bus.c_addr  = 5'd3;
    bus.c_data  = 32'h0000_0333;
    bus.d_valid = 1'b1;
    bus.d_addr  = 5'd7;
    bus.d_data  = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if ({bus.c_ready, bus.d_ready} !== 2'b10) begin
        n_fail++;
        $display("FAIL cont_ready cyc%0d got %b exp 10", i, {bus.c_ready, bus.d_ready});
      end
      tick();
      n_checks++;
      if (bus.starve_cnt !== 4'(i + 1)) begin
        n_fail++; $display("FAIL cont_cnt cyc%0d got %0d exp %0d", i, bus.starve_cnt, i + 1);
      end
      n_checks++;
      if (bus.rf_wrt_addr !== 5'd3) begin
        n_fail++; $display("FAIL cont_core_addr cyc%0d got %0d exp 3", i, bus.rf_wrt_addr);
      end
    end
    #1;
    n_checks++;
    if ({bus.c_ready, bus.d_ready} !== 2'b01) begin
      n_fail++; $display("FAIL cont_forced got %b exp 01", {bus.c_ready, bus.d_ready});
    end
    tick();
    n_checks++;
    if ({bus.rf_wrt_en, bus.rf_wrt_addr, bus.rf_wrt_data} !== {1'b1, 5'd7, 32'h12345678}) begin
      n_fail++;
      $display("FAIL cont_dbg_write got en=%0h addr=%0d data=%h exp en=1 addr=7 data=12345678",
               bus.rf_wrt_en, bus.rf_wrt_addr, bus.rf_wrt_data);
    end
    n_checks++;
    if (bus.starve_cnt !== 4'd0) begin
      n_fail++; $display("FAIL cont_cnt_clr got %0d exp 0", bus.starve_cnt);
    end
    n_checks++;
    if ({bus.c_ready, bus.d_ready} !== 2'b10) begin
      n_fail++; $display("FAIL cont_core_back got %b exp 10", {bus.c_ready, bus.d_ready});
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_x0();
    bus.d_valid = 1'b1;
    bus.d_addr  = 5'd0;
    bus.d_data  = 32'hFFFFFFFF;
    #1;
    n_checks++;
    if ({bus.c_ready, bus.d_ready} !== 2'b01) begin
      n_fail++; $display("FAIL x0_ready got %b exp 01", {bus.c_ready, bus.d_ready});
    end
    tick();
    bus.d_valid = 1'b0;
    n_checks++;
    if ({bus.rf_wrt_en, bus.rf_wrt_addr, bus.rf_wrt_data} !== {1'b0, 5'd0, 32'hFFFFFFFF}) begin
      n_fail++;
      $display("FAIL x0_write got en=%0h addr=%0d data=%h exp en=0 addr=0 data=ffffffff",
               bus.rf_wrt_en, bus.rf_wrt_addr, bus.rf_wrt_data);
    end
    tick();
  endtask

  task automatic test_freeze();
    bus.c_valid = 1'b1;
    bus.c_addr  = 5'd10;
    bus.c_data  = 32'hAAAA0000;
    bus.d_valid = 1'b1;
    bus.d_addr  = 5'd11;
    bus.d_data  = 32'hBBBB0000;
    tick();
    tick();
    n_checks++;
    if (bus.starve_cnt !== 4'd2) begin
      n_fail++; $display("FAIL frz_pre_cnt got %0d exp 2", bus.starve_cnt);
    end
    bus.freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({bus.c_ready, bus.d_ready} !== 2'b00) begin
        n_fail++;
        $display("FAIL frz_ready cyc%0d got %b exp 00", i, {bus.c_ready, bus.d_ready});
      end
      tick();
      n_checks++;
      if ({bus.rf_wrt_en, bus.starve_cnt} !== {1'b0, 4'd2}) begin
        n_fail++;
        $display("FAIL frz_hold cyc%0d got en=%0h cnt=%0d exp en=0 cnt=2",
                 i, bus.rf_wrt_en, bus.starve_cnt);
      end
    end
    bus.freeze = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if ({bus.c_ready, bus.d_ready} !== 2'b10) begin
        n_fail++;
        $display("FAIL frz_core cyc%0d got %b exp 10", i, {bus.c_ready, bus.d_ready});
      end
      tick();
      n_checks++;
      if ({bus.rf_wrt_en, bus.rf_wrt_addr} !== {1'b1, 5'd10}) begin
        n_fail++;
        $display("FAIL frz_core_write cyc%0d got en=%0h addr=%0d exp en=1 addr=10",
                 i, bus.rf_wrt_en, bus.rf_wrt_addr);
      end
    end
    #1;
    n_checks++;
    if ({bus.c_ready, bus.d_ready} !== 2'b01) begin
      n_fail++; $display("FAIL frz_forced got %b exp 01", {bus.c_ready, bus.d_ready});
    end
    tick();
    n_checks++;
    if ({bus.rf_wrt_addr, bus.starve_cnt} !== {5'd11, 4'd0}) begin
      n_fail++;
      $display("FAIL frz_dbg_write got addr=%0d cnt=%0d exp addr=11 cnt=0",
               bus.rf_wrt_addr, bus.starve_cnt);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    bus.c_valid = 1'b1;
    bus.c_addr  = 5'd9;
    bus.c_data  = 32'h99990001;
    tick();
    bus.c_data  = 32'h99990002;
    tick();
    n_checks++;
    if ({bus.rf_wrt_en, bus.rf_wrt_addr} !== {1'b1, 5'd9}) begin
      n_fail++;
      $display("FAIL rmid_stream got en=%0h addr=%0d exp en=1 addr=9",
               bus.rf_wrt_en, bus.rf_wrt_addr);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.rf_wrt_en, bus.rf_wrt_addr, bus.rf_wrt_data, bus.starve_cnt} !== 42'd0) begin
      n_fail++;
      $display("FAIL rmid_async got en=%0h addr=%0d data=%h cnt=%0d exp all 0",
               bus.rf_wrt_en, bus.rf_wrt_addr, bus.rf_wrt_data, bus.starve_cnt);
    end
    n_checks++;
    if ({bus.c_ready, bus.d_ready} !== 2'b10) begin
      n_fail++; $display("FAIL rmid_ready got %b exp 10", {bus.c_ready, bus.d_ready});
    end
    tick();
    n_checks++;
    if ({bus.rf_wrt_en, bus.rf_wrt_addr} !== {1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL rmid_no_pulse got en=%0h addr=%0d exp en=0 addr=0",
               bus.rf_wrt_en, bus.rf_wrt_addr);
    end
    bus.c_valid = 1'b0;
    #2 reset = 1'b0;
    tick();
    n_checks++;
    if (bus.rf_wrt_en !== 1'b0) begin
      n_fail++; $display("FAIL rmid_after got en=%0h exp 0", bus.rf_wrt_en);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_core_only();
    test_contention();
    test_x0();
    test_freeze();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port between the core writeback stage and the debug module. Each requester has its own valid/ready handshake. The arbiter picks one winner per cycle: fixed priority to the core, with a starvation counter that eventually forces a debug grant. The winning write goes through one register stage and then drives the register file's write-enable, write-address and write-data inputs. Writes to x0 are accepted but never reach the register file.

## Interface
- STARVE_MAX, 4: maximum consecutive cycles debug may be denied while it is requesting; legal range 1..15.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- freeze  in  1  when 1, no grants are issued and the starvation counter holds.
- c_valid  in  1  core writeback request.
- c_addr  in  5  core destination register.
- c_data  in  32  core write data.
- c_ready  out  1  core request accepted this cycle (combinational).
- d_valid  in  1  debug write request.
- d_addr  in  5  debug destination register.
- d_data  in  32  debug write data.
- d_ready  out  1  debug request accepted this cycle (combinational).
- rf_wrt_en  out  1  register-file write enable (registered).
- rf_wrt_addr  out  5  register-file write address (registered).
- rf_wrt_data  out  32  register-file write data (registered).
- starve_cnt  out  4  current starvation count, for observation.

## Operation
- A transfer happens on a rising edge where valid && ready.
- At most one of c_ready and d_ready is 1 in any cycle.
- Grant rules, evaluated combinationally in this order:
  - freeze=1: c_ready=0 and d_ready=0.
  - d_valid && starve_cnt==STARVE_MAX: debug wins (forced grant).
  - c_valid: core wins.
  - d_valid: debug wins.
  - Otherwise: no grant.
- ready depends on valid, freeze and starve_cnt only. It never depends on the requester's data.
- Starvation counter, updated on each rising edge:
  - If d_valid && c_ready && !freeze: starve_cnt += 1, saturating at STARVE_MAX.
  - Else if d_ready or !d_valid: starve_cnt = 0.
  - Else (freeze=1): hold.
- Output stage, on the edge of a transfer:
  - rf_wrt_addr and rf_wrt_data load the winner's address and data.
  - rf_wrt_en = (winner address != 0).
- On an edge with no transfer: rf_wrt_en=0; rf_wrt_addr and rf_wrt_data hold their previous values.
- An x0 write completes its handshake normally. It loads address 0 and the data into the output stage, but rf_wrt_en stays 0.
- No buffering. A requester that is not granted must hold valid, addr and data stable until it sees ready.
- Reset, asynchronous and taking effect mid-operation:
  - rf_wrt_en=0, rf_wrt_addr=0, rf_wrt_data=0, starve_cnt=0.
  - c_ready and d_ready follow the grant rules using starve_cnt=0. While reset is asserted no transfer takes effect.
  - A write accepted in the same cycle that reset asserts is lost.

## Timing
- Latency from handshake edge to rf_wrt_en high: 1 cycle. The register file itself commits on the following edge.
- Throughput: one write per cycle, sustained, across either requester.
- A forced debug grant occurs at the latest on the (STARVE_MAX+1)th cycle of continuous d_valid.
- After a forced grant the counter is 0 and the core regains priority on the next cycle.
- freeze asserted mid-starvation: the counter holds its value and is not reset.
- When both requesters are valid, starve_cnt==STARVE_MAX and freeze=1: no grant. The forced grant happens on the first cycle after freeze drops.

## Test plan
- Reset release with no requests -> rf_wrt_en=0, rf_wrt_addr=0, rf_wrt_data=0, starve_cnt=0; c_ready=d_ready=0.
- Core only: c_valid=1, c_addr=5, c_data=0xDEADBEEF for one cycle -> c_ready=1 that cycle; the next cycle rf_wrt_en=1, rf_wrt_addr=5, rf_wrt_data=0xDEADBEEF; the cycle after, rf_wrt_en=0.
- Contention, STARVE_MAX=4: c_valid and d_valid held high, with d_addr=7 and d_data=0x12345678 -> core granted cycles 0-3 while starve_cnt counts 1..4; debug granted cycle 4; rf_wrt_addr=7 in cycle 5; starve_cnt=0 after cycle 4; core granted cycle 5.
- x0 suppression: d_valid=1, d_addr=0, d_data=0xFFFFFFFF, core idle -> d_ready=1; next cycle rf_wrt_en=0, rf_wrt_addr=0, rf_wrt_data=0xFFFFFFFF.
- Freeze: both requesters valid, starve_cnt=2, freeze=1 for 3 cycles -> no grants, starve_cnt stays 2; after freeze drops, core granted 2 cycles, then debug forced.
- Reset mid-stream: assert reset while core writes to addr 9 are streaming -> outputs go to 0 immediately, with no clock edge needed; no rf_wrt_en pulse for the in-flight write; starve_cnt=0.
